mem_access_arbiter: RTL and testbench

Sequences all accesses to the single-ported word memory in the multicycle MIPS core. Arbitrates between the instruction-fetch port and the load/store port, translates each MIPS byte address into a word index relative to the text base, and rejects misaligned or out-of-range addresses before they reach memory. Sits between the control-unit/datapath requesters and the memory array.

---
 rtl/mem_access_arbiter_pkg.sv | 6 +
 rtl/mem_access_arbiter_if.sv | 32 +++
 rtl/mem_access_arbiter_va_translate.sv | 18 +
 rtl/mem_access_arbiter.sv | 106 ++++++++++
 tb/tb_mem_access_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// mips_mem_pkg: shared text base, FSM state and port-id types for the memory arbiter
package mips_mem_pkg;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_e;
  typedef enum logic {PORT_IF, PORT_LS} port_e;
endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: fetch, load/store, memory and error signals; slave = arbiter side, master = requester/memory side
interface mem_access_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 10
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_done;
  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_done;
  logic [IDX_WIDTH-1:0]  mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  err;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic                  busy;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_rdata, if_done, ls_rdata, ls_done, mem_addr, mem_we, mem_wdata, err, err_addr, busy
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_rdata, if_done, ls_rdata, ls_done, mem_addr, mem_we, mem_wdata, err, err_addr, busy
  );
endinterface

// File: rtl/mem_access_arbiter_va_translate.sv
// va_translate: byte address (addr_i) -> word index from text base (idx_o) with misalignment (align_err_o) and range (range_err_o) flags
module va_translate
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_WIDTH-1:0]  idx_o,
  output logic                  align_err_o,
  output logic                  range_err_o
);
  logic [ADDR_WIDTH-1:0] off;
  assign off         = addr_i - ADDR_WIDTH'(TEXT_BASE);
  assign idx_o       = off[IDX_WIDTH+1:2];
  assign align_err_o = |off[1:0];
  assign range_err_o = (addr_i < ADDR_WIDTH'(TEXT_BASE)) || (|off[ADDR_WIDTH-1:IDX_WIDTH+2]);
endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: arbitrates fetch/load-store requests onto one word memory (clk, reset, bus = slave side of mem_access_arbiter_if)
module mem_access_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_WIDTH   = 10,
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  mem_access_arbiter_if.slave bus
);
  state_e                state_q, state_d;
  port_e                 sel_q, sel_d, last_q, last_d, pick;
  logic [2:0]            cnt_q, cnt_d;
  logic                  we_q, we_d, mem_we_q, mem_we_d;
  logic [IDX_WIDTH-1:0]  mem_addr_q, mem_addr_d, idx;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d, addr;
  logic                  align_err, range_err;
  assign pick = (bus.if_req && bus.ls_req) ? (last_q == PORT_LS ? PORT_IF : PORT_LS)
                                           : (bus.if_req ? PORT_IF : PORT_LS);
  assign addr = pick == PORT_IF ? bus.if_addr : bus.ls_addr;
  va_translate #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_xlate (
    .addr_i(addr), .idx_o(idx), .align_err_o(align_err), .range_err_o(range_err)
  );
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      IDLE: if (bus.if_req || bus.ls_req) begin
        sel_d = pick;
        we_d  = pick == PORT_LS && bus.ls_we;
        if (align_err || range_err) begin
          state_d    = ERR;
          err_addr_d = addr;
        end else begin
          state_d     = ACCESS;
          cnt_d       = 3'(MEM_LATENCY);
          mem_addr_d  = idx;
          mem_we_d    = we_d;
          mem_wdata_d = we_d ? bus.ls_wdata : mem_wdata_q;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d    = RESP;
          if_rdata_d = sel_q == PORT_IF ? bus.mem_rdata : if_rdata_q;
          ls_rdata_d = (sel_q == PORT_LS && !we_q) ? bus.mem_rdata : ls_rdata_q;
        end
      end
      default: begin
        state_d = IDLE;
        last_d  = sel_q;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= PORT_IF;
      last_q      <= PORT_LS;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      err_addr_q  <= err_addr_d;
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.err       = state_q == ERR;
  assign bus.if_done   = (state_q == RESP || state_q == ERR) && sel_q == PORT_IF;
  assign bus.ls_done   = (state_q == RESP || state_q == ERR) && sel_q == PORT_LS;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.err_addr  = err_addr_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: scoreboard bench for mem_access_arbiter at MEM_LATENCY 1 (dut1) and 3 (dut2)
module tb_mem_access_arbiter;
  import mips_mem_pkg::*;
  typedef struct {
    port_e       port;
    logic        err;
    int          cyc;
    logic [31:0] rdata;
    logic [31:0] eaddr;
  } resp_t;
  typedef struct {
    logic [9:0]  idx;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  logic clk = 1'b0;
  logic rst1, rst2;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  resp_t q1[$];
  resp_t q2[$];
  wr_t w1[$];
  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_access_arbiter_if a ();
  mem_access_arbiter_if b ();
  mem_access_arbiter #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(rst1), .bus(a.slave));
  mem_access_arbiter #(.MEM_LATENCY(3)) dut2 (.clk(clk), .reset(rst2), .bus(b.slave));
  assign a.mem_rdata = mem1[a.mem_addr];
  assign b.mem_rdata = mem2[b.mem_addr];
  always @(posedge clk) begin
    if (a.mem_we) mem1[a.mem_addr] <= a.mem_wdata;
    if (b.mem_we) mem2[b.mem_addr] <= b.mem_wdata;
  end
  function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction
  function automatic void cmp(input string t, input resp_t e, input logic ifd, input logic er,
                              input logic [31:0] ifr, input logic [31:0] lsr, input logic [31:0] ea);
    chk({t, "_port_is_if"}, 64'(ifd), 64'(e.port == PORT_IF));
    chk({t, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
    chk({t, "_err"}, 64'(er), 64'(e.err));
    if (e.err) chk({t, "_err_addr"}, 64'(ea), 64'(e.eaddr));
    else chk({t, "_rdata"}, 64'(ifd ? ifr : lsr), 64'(e.rdata));
  endfunction
  always @(negedge clk) begin
    if (a.if_done || a.ls_done) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 64'(1), 64'(0));
      else cmp("dut1", q1.pop_front(), a.if_done, a.err, a.if_rdata, a.ls_rdata, a.err_addr);
    end
    if (b.if_done || b.ls_done) begin
      if (q2.size() == 0) chk("dut2_unexpected_done", 64'(1), 64'(0));
      else cmp("dut2", q2.pop_front(), b.if_done, b.err, b.if_rdata, b.ls_rdata, b.err_addr);
    end
    if (a.mem_we) begin
      if (w1.size() == 0) chk("dut1_unexpected_mem_we", 64'(1), 64'(0));
      else begin
        wr_t w;
        w = w1.pop_front();
        chk("mem_we_idx", 64'(a.mem_addr), 64'(w.idx));
        chk("mem_we_data", 64'(a.mem_wdata), 64'(w.data));
        chk("mem_we_cycle", 64'(cyc), 64'(w.cyc));
      end
    end
    if (b.mem_we) chk("dut2_unexpected_mem_we", 64'(1), 64'(0));
  end
  task automatic waitdone(input bit is_if, input string t);
    int n = 0;
    while (!(is_if ? a.if_done : a.ls_done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({t, "_timeout"}, 64'(0), 64'(1));
  endtask
  task automatic one(input port_e p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic exp_err, input logic [31:0] exp_rd, input logic [9:0] idx, input bit drop);
    int ac;
    @(negedge clk);
    if (p == PORT_IF) begin
      a.if_req  = 1'b1;
      a.if_addr = addr;
    end else begin
      a.ls_req   = 1'b1;
      a.ls_we    = we;
      a.ls_addr  = addr;
      a.ls_wdata = wd;
    end
    ac = cyc + 1;
    q1.push_back('{p, exp_err, exp_err ? ac : ac + 1, exp_rd, addr});
    if (we && !exp_err) w1.push_back('{idx, wd, ac});
    @(negedge clk);
    chk("busy_cycle1", 64'(a.busy), 64'(1));
    if (!exp_err) chk("mem_addr_cycle1", 64'(a.mem_addr), 64'(idx));
    if (drop) begin
      a.if_req = 1'b0;
      a.ls_req = 1'b0;
    end
    waitdone(p == PORT_IF, "one");
    a.if_req = 1'b0;
    a.ls_req = 1'b0;
  endtask
  initial begin
    int c;
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'hA500_0000 + 32'(i);
      mem2[i] = 32'h5A00_0000 + 32'(i);
    end
    {a.if_req, a.ls_req, a.ls_we} = '0;
    {a.if_addr, a.ls_addr, a.ls_wdata} = '0;
    {b.if_req, b.ls_req, b.ls_we} = '0;
    {b.if_addr, b.ls_addr, b.ls_wdata} = '0;
    rst1 = 1'b1;
    rst2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(a.busy), 64'(0));
    chk("rst_if_done", 64'(a.if_done), 64'(0));
    chk("rst_ls_done", 64'(a.ls_done), 64'(0));
    chk("rst_err", 64'(a.err), 64'(0));
    chk("rst_err_addr", 64'(a.err_addr), 64'(0));
    chk("rst_mem_addr", 64'(a.mem_addr), 64'(0));
    chk("rst_mem_we", 64'(a.mem_we), 64'(0));
    chk("rst_mem_wdata", 64'(a.mem_wdata), 64'(0));
    chk("rst_if_rdata", 64'(a.if_rdata), 64'(0));
    chk("rst_ls_rdata", 64'(a.ls_rdata), 64'(0));
    chk("rst2_busy", 64'(b.busy), 64'(0));
    rst1 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    a.if_req = 1'b1; a.if_addr = 32'h0040_0008;
    a.ls_req = 1'b1; a.ls_we = 1'b0; a.ls_addr = 32'h0040_000C;
    c = cyc;
    q1.push_back('{PORT_IF, 1'b0, c + 2, 32'hA500_0002, 32'h0});
    q1.push_back('{PORT_LS, 1'b0, c + 5, 32'hA500_0003, 32'h0});
    waitdone(1'b1, "tie1_if");
    a.if_req = 1'b0;
    waitdone(1'b0, "tie1_ls");
    a.ls_req = 1'b0;
    @(negedge clk);
    a.if_req = 1'b1; a.if_addr = 32'h0040_0000;
    a.ls_req = 1'b1; a.ls_addr = 32'h0040_0004;
    c = cyc;
    q1.push_back('{PORT_IF, 1'b0, c + 2, 32'hA500_0000, 32'h0});
    q1.push_back('{PORT_LS, 1'b0, c + 5, 32'hA500_0001, 32'h0});
    waitdone(1'b1, "tie2_if");
    a.if_req = 1'b0;
    waitdone(1'b0, "tie2_ls");
    a.ls_req = 1'b0;
    one(PORT_IF, 1'b0, 32'h0040_0008, 32'h0,         1'b0, 32'hA500_0002, 10'd2,    1'b0);
    one(PORT_LS, 1'b1, 32'h0040_0010, 32'hDEAD_BEEF, 1'b0, 32'hA500_0001, 10'd4,    1'b0);
    one(PORT_LS, 1'b0, 32'h0040_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 10'd4,    1'b0);
    one(PORT_LS, 1'b0, 32'h0040_0006, 32'h0,         1'b1, 32'h0,         10'd0,    1'b0);
    one(PORT_IF, 1'b0, 32'h003F_FFFC, 32'h0,         1'b1, 32'h0,         10'd0,    1'b0);
    one(PORT_IF, 1'b0, 32'h0040_1000, 32'h0,         1'b1, 32'h0,         10'd0,    1'b0);
    one(PORT_IF, 1'b0, 32'h0040_0FFC, 32'h0,         1'b0, 32'hA500_03FF, 10'd1023, 1'b0);
    one(PORT_IF, 1'b0, 32'h0040_0014, 32'h0,         1'b0, 32'hA500_0005, 10'd5,    1'b1);
    one(PORT_LS, 1'b1, 32'h0040_0020, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 10'd8,    1'b0);
    repeat (3) @(negedge clk);
    chk("if_rdata_hold", 64'(a.if_rdata), 64'(32'hA500_0005));
    chk("err_addr_hold", 64'(a.err_addr), 64'(32'h0040_1000));
    chk("mem8_written", 64'(mem1[8]), 64'(32'h1234_5678));
    chk("dut1_resp_queue_empty", 64'(q1.size()), 64'(0));
    chk("dut1_write_queue_empty", 64'(w1.size()), 64'(0));
    @(negedge clk);
    b.if_req = 1'b1; b.if_addr = 32'h0040_0014;
    c = cyc;
    q2.push_back('{PORT_IF, 1'b0, c + 4, 32'h5A00_0005, 32'h0});
    for (int n = 0; n < 20 && !b.if_done; n++) @(negedge clk);
    b.if_req = 1'b0;
    @(negedge clk);
    b.if_req = 1'b1; b.if_addr = 32'h0040_0018;
    @(negedge clk);
    chk("dut2_busy_access1", 64'(b.busy), 64'(1));
    chk("dut2_mem_addr", 64'(b.mem_addr), 64'(6));
    @(negedge clk);
    rst2 = 1'b1;
    b.if_req = 1'b0;
    @(negedge clk);
    chk("dut2_rst_busy", 64'(b.busy), 64'(0));
    chk("dut2_rst_done", 64'(b.if_done), 64'(0));
    chk("dut2_rst_mem_addr", 64'(b.mem_addr), 64'(0));
    chk("dut2_rst_if_rdata", 64'(b.if_rdata), 64'(0));
    chk("dut2_rst_err", 64'(b.err), 64'(0));
    rst2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("dut2_idle_after_rst", 64'(b.busy), 64'(0));
    chk("dut2_resp_queue_empty", 64'(q2.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
